// File: rtl/tick_deframer.sv
`timescale 1ns/1ps
// tick_deframer: hunts 6-byte tick frames (SYNC, P3..P0, XOR checksum) and emits Q16.16 prices.
// Optional build macro TICK_PRICE_FILTER_EN drops checked frames whose price is <= 0.
module tick_deframer #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_byte,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [15:0]          frame_count
);

   typedef enum logic [1:0] {
      S_HUNT = 2'd0,
      S_PAY  = 2'd1,
      S_CHK  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [1:0]             r_idx;
   logic [31:0]            r_price;
   logic [7:0]             r_xor;
   logic                   r_out_valid;
   logic [31:0]            r_out_data;
   logic [ERR_CNT_W-1:0]   r_err_count;
   logic [15:0]            r_frame_count;
   logic                   w_in_ready;
   logic                   w_accept;
   logic                   w_price_ok;
   logic                   w_load;
   logic                   w_drop;

   // The checksum byte waits until the output register has room for its result.
   assign w_in_ready = (r_state != S_CHK) || !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;

`ifdef TICK_PRICE_FILTER_EN
   assign w_price_ok = !r_price[31] && (r_price != 32'd0);
`else
   assign w_price_ok = 1'b1;
`endif

   // Next-state and frame accept/drop decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         S_HUNT: begin
            if (w_accept && (in_byte == SYNC_BYTE)) begin
               w_state_nxt = S_PAY;
            end else begin
               w_state_nxt = S_HUNT;
            end
         end
         S_PAY: begin
            if (w_accept && (r_idx == 2'd3)) begin
               w_state_nxt = S_CHK;
            end else begin
               w_state_nxt = S_PAY;
            end
         end
         S_CHK: begin
            if (w_accept) begin
               w_state_nxt = S_HUNT;
               if ((in_byte == r_xor) && w_price_ok) begin
                  w_load = 1'b1;
               end else begin
                  w_drop = 1'b1;
               end
            end else begin
               w_state_nxt = S_CHK;
            end
         end
         default: begin
            w_state_nxt = S_HUNT;
         end
      endcase
   end

   // State register plus payload shift and running XOR.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_HUNT;
         r_idx   <= 2'd0;
         r_price <= 32'd0;
         r_xor   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            case (r_state)
               S_HUNT: begin
                  r_idx <= 2'd0;
                  r_xor <= 8'd0;
               end
               S_PAY: begin
                  r_price <= {r_price[23:0], in_byte};
                  r_xor   <= r_xor ^ in_byte;
                  r_idx   <= r_idx + 2'd1;
               end
               default: begin
                  r_idx <= r_idx;
               end
            endcase
         end
      end
   end

   // Output register: a reload in the drain cycle wins and keeps valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 32'd0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= r_price;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Frame counter wraps, error counter saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_count <= 16'd0;
         r_err_count   <= {ERR_CNT_W{1'b0}};
      end else begin
         if (w_load) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
         if (w_drop && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
         end
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign err_count   = r_err_count;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_tick_deframer.sv
`timescale 1ns/1ps
// Scoreboard bench for tick_deframer: stimulus pushes expected prices, a negedge monitor pops them.
module tb_tick_deframer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        sat_valid;
   logic        out_ready;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [15:0] err_count;
   logic [15:0] frame_count;
   logic        sat_ready;
   logic        sat_ovalid;
   logic [31:0] sat_odata;
   logic [1:0]  sat_err;
   logic [15:0] sat_frames;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   bit          use_sat = 1'b0;
   logic        p_hold = 1'b0;
   logic [31:0] p_data = 32'd0;

   always #5 clk = ~clk;

   tick_deframer #(.SYNC_BYTE(8'hA5), .ERR_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err_count(err_count), .frame_count(frame_count)
   );

   tick_deframer #(.SYNC_BYTE(8'hA5), .ERR_CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(sat_valid), .in_ready(sat_ready), .in_byte(in_byte),
      .out_valid(sat_ovalid), .out_ready(out_ready), .out_data(sat_odata),
      .err_count(sat_err), .frame_count(sat_frames)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every drained word must match the oldest expected price.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
         end else begin
            check("out_data_scoreboard", out_data, exp_q.pop_front());
         end
      end
      if (p_hold && !rst) check("hold_stable", out_data, p_data);
      p_hold <= out_valid && !out_ready && !rst;
      p_data <= out_data;
   end

   task automatic send(input logic [7:0] b);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      in_byte = b;
      if (use_sat) sat_valid = 1'b1;
      else in_valid = 1'b1;
      while (!ok && n < 50) begin
         #1;
         ok = use_sat ? sat_ready : in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check("accept_timeout", {31'd0, ok}, 32'd1);
      in_valid  = 1'b0;
      sat_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] p, input logic [7:0] chk);
      send(8'hA5);
      send(p[31:24]);
      send(p[23:16]);
      send(p[15:8]);
      send(p[7:0]);
      send(chk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; sat_valid = 1'b0; in_byte = 8'd0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_err", err_count, 32'd0);
      check("rst_frames", frame_count, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Basic frame, 1.5 in Q16.16
      send(8'hA5); send(8'h00); send(8'h01); send(8'h80); send(8'h00);
      check("basic_pre_valid", {31'd0, out_valid}, 32'd0);
      exp_q.push_back(32'h0001_8000);
      send(8'h81);
      check("basic_valid", {31'd0, out_valid}, 32'd1);
      check("basic_data", out_data, 32'h0001_8000);
      check("basic_frames", frame_count, 32'd1);
      @(posedge clk); #1;
      check("basic_one_cycle", {31'd0, out_valid}, 32'd0);

      // Bad checksum then resync
      do_reset();
      send(8'h11); send(8'h22);
      send(8'hA5); send(8'h00); send(8'h01); send(8'h80); send(8'h00); send(8'h00);
      check("badchk_err", err_count, 32'd1);
      check("badchk_frames", frame_count, 32'd0);
      check("badchk_valid", {31'd0, out_valid}, 32'd0);
      exp_q.push_back(32'h0002_0000);
      send_frame(32'h0002_0000, 8'h02);
      check("resync_data", out_data, 32'h0002_0000);
      check("resync_frames", frame_count, 32'd1);
      check("resync_err", err_count, 32'd1);
      @(posedge clk); #1;

      // Backpressure across two back-to-back frames
      do_reset();
      out_ready = 1'b0;
      exp_q.push_back(32'h0004_0000);
      exp_q.push_back(32'h0005_0000);
      send_frame(32'h0004_0000, 8'h04);
      check("bp_first_valid", {31'd0, out_valid}, 32'd1);
      check("bp_first_data", out_data, 32'h0004_0000);
      send(8'hA5); send(8'h00); send(8'h05); send(8'h00); send(8'h00);
      in_byte = 8'h05; in_valid = 1'b1;
      #1;
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("bp_held_data", out_data, 32'h0004_0000);
      check("bp_held_frames", frame_count, 32'd1);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check("bp_second_valid", {31'd0, out_valid}, 32'd1);
      check("bp_second_data", out_data, 32'h0005_0000);
      check("bp_second_frames", frame_count, 32'd2);
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_drained", {31'd0, out_valid}, 32'd0);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Negative price
      do_reset();
`ifdef TICK_PRICE_FILTER_EN
      send_frame(32'hFFFF_0000, 8'h00);
      check("neg_err", err_count, 32'd1);
      check("neg_frames", frame_count, 32'd0);
      check("neg_valid", {31'd0, out_valid}, 32'd0);
`else
      exp_q.push_back(32'hFFFF_0000);
      send_frame(32'hFFFF_0000, 8'h00);
      check("neg_data", out_data, 32'hFFFF_0000);
      check("neg_frames", frame_count, 32'd1);
      check("neg_err", err_count, 32'd0);
`endif
      @(posedge clk); #1;

      // Reset mid-frame
      do_reset();
      send(8'hA5); send(8'h00); send(8'h01);
      do_reset();
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(32'h0003_0000);
      send_frame(32'h0003_0000, 8'h03);
      check("midrst_data", out_data, 32'h0003_0000);
      check("midrst_frames", frame_count, 32'd1);
      check("midrst_err", err_count, 32'd0);
      @(posedge clk); #1;

      // Error counter saturation on a 2-bit counter
      do_reset();
      use_sat = 1'b1;
      repeat (3) send_frame(32'h0102_0304, 8'h00);
      check("sat_err_3", sat_err, 32'd3);
      repeat (2) send_frame(32'h0102_0304, 8'h00);
      check("sat_err_hold", sat_err, 32'd3);
      check("sat_frames", sat_frames, 32'd0);
      check("sat_no_output", {31'd0, sat_ovalid}, 32'd0);
      use_sat = 1'b0;

      @(posedge clk); #1;
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
